reg_writeback: RTL

Writeback arbiter that drives the register file's single write port. It merges two producers: single-cycle ALU results, buffered in a 2-entry FIFO, and load-unit results, which are sign- or zero-extended here. It emits one registered write per cycle on `reg_write` / `write_reg_num1` / `write_data`. It sits between the execute/memory stages and the register file and is the only writer of that port.

---
 rtl/reg_writeback.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/reg_writeback.sv
// reg_writeback: sole driver of the register-file write port.
// Merges ALU results, which are buffered in a 2-entry FIFO, with load results,
// which are byte/half selected and extended here. Loads have priority, but a
// 2-bit streak counter forces a FIFO grant after three consecutive load grants
// while ALU work is waiting, so the ALU path cannot be starved.
module reg_writeback (
    input  logic        clk,
    input  logic        rst,            // asynchronous, active-low
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_result,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [4:0]  ld_rd,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] ld_rdata,
    output logic        reg_write,
    output logic [4:0]  write_reg_num1,
    output logic [31:0] write_data,
    output logic        ld_err
);

    localparam int          DEPTH      = 2;
    localparam logic [1:0]  CNT_FULL   = 2'd2;
    localparam logic [1:0]  STREAK_MAX = 2'd3;

    localparam logic [2:0]  F3_LB  = 3'd0;
    localparam logic [2:0]  F3_LH  = 3'd1;
    localparam logic [2:0]  F3_LW  = 3'd2;
    localparam logic [2:0]  F3_LBU = 3'd4;
    localparam logic [2:0]  F3_LHU = 3'd5;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]  count_q,  count_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [1:0]  streak_q, streak_d;

    logic [4:0]  fifo_rd_q   [DEPTH];
    logic [31:0] fifo_data_q [DEPTH];

    logic        reg_write_q, reg_write_d;
    logic [4:0]  wr_num_q,    wr_num_d;
    logic [31:0] wr_data_q,   wr_data_d;
    logic        ld_err_q,    ld_err_d;

    // ------------------------------------------------------------------
    // Handshake and arbitration
    // ------------------------------------------------------------------
    logic        fifo_nonempty;
    logic        force_fifo;
    logic        push;
    logic        ld_grant;
    logic        fifo_grant;
    logic [4:0]  head_rd;
    logic [31:0] head_data;

    assign fifo_nonempty = (count_q != 2'd0);

    // After three load grants with ALU work pending, the next slot goes to the FIFO.
    assign force_fifo = (streak_q == STREAK_MAX) && fifo_nonempty;

    // Both readies are functions of state only; gating with rst keeps them
    // low for the whole time reset is held, not just after the first edge.
    assign alu_ready = rst && (count_q != CNT_FULL);
    assign ld_ready  = rst && !force_fifo;

    assign push       = alu_valid && alu_ready;
    assign ld_grant   = ld_valid && ld_ready;
    assign fifo_grant = !ld_grant && fifo_nonempty;

    assign head_rd   = fifo_rd_q[rd_ptr_q];
    assign head_data = fifo_data_q[rd_ptr_q];

    // ------------------------------------------------------------------
    // Load formatting and error detection
    // ------------------------------------------------------------------
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_fmt;
    logic        ld_bad;

    assign ld_byte = ld_rdata[{ld_addr_lo, 3'b000} +: 8];
    assign ld_half = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];

    // Select and extend the addressed lane; illegal types produce zero data.
    always_comb begin
        ld_fmt = 32'd0;
        case (ld_funct3)
            F3_LB:   ld_fmt = {{24{ld_byte[7]}}, ld_byte};
            F3_LBU:  ld_fmt = {24'd0, ld_byte};
            F3_LH:   ld_fmt = {{16{ld_half[15]}}, ld_half};
            F3_LHU:  ld_fmt = {16'd0, ld_half};
            F3_LW:   ld_fmt = ld_rdata;
            default: ld_fmt = 32'd0;
        endcase
    end

    // Flag unsupported load types and misaligned halfword/word accesses.
    always_comb begin
        ld_bad = 1'b0;
        case (ld_funct3)
            F3_LB, F3_LBU: ld_bad = 1'b0;
            F3_LH, F3_LHU: ld_bad = ld_addr_lo[0];
            F3_LW:         ld_bad = (ld_addr_lo != 2'd0);
            default:       ld_bad = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO bookkeeping
    // ------------------------------------------------------------------
    // Occupancy and pointer updates; a push while full cannot happen
    // because alu_ready is low then.
    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (fifo_grant) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, fifo_grant})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Fairness streak: counts load grants taken while ALU work is waiting.
    always_comb begin
        streak_d = streak_q;
        if (!fifo_nonempty || fifo_grant) begin
            streak_d = 2'd0;
        end else if (ld_grant) begin
            streak_d = streak_q + 2'd1;
        end
    end

    // Control state register; reset also empties the FIFO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            streak_q <= 2'd0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            streak_q <= streak_d;
        end
    end

    // FIFO payload storage; contents are only meaningful under count_q.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic entry_we;
            assign entry_we = push && (wr_ptr_q == 1'(gi));

            // Capture the ALU result into this slot when it is the write target.
            always_ff @(posedge clk) begin
                if (entry_we) begin
                    fifo_rd_q[gi]   <= alu_rd;
                    fifo_data_q[gi] <= alu_result;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Write-port output
    // ------------------------------------------------------------------
    // Choose this cycle's write: the granted load, else the FIFO head,
    // else a bubble that holds destination and data.
    always_comb begin
        reg_write_d = 1'b0;
        ld_err_d    = 1'b0;
        wr_num_d    = wr_num_q;
        wr_data_d   = wr_data_q;
        if (ld_grant) begin
            wr_num_d    = ld_rd;
            wr_data_d   = ld_fmt;
            reg_write_d = !ld_bad && (ld_rd != 5'd0);
            ld_err_d    = ld_bad;
        end else if (fifo_grant) begin
            wr_num_d    = head_rd;
            wr_data_d   = head_data;
            reg_write_d = (head_rd != 5'd0);
        end
    end

    // Output registers; asynchronous clear drops any write in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_write_q <= 1'b0;
            wr_num_q    <= 5'd0;
            wr_data_q   <= 32'd0;
            ld_err_q    <= 1'b0;
        end else begin
            reg_write_q <= reg_write_d;
            wr_num_q    <= wr_num_d;
            wr_data_q   <= wr_data_d;
            ld_err_q    <= ld_err_d;
        end
    end

    assign reg_write      = reg_write_q;
    assign write_reg_num1 = wr_num_q;
    assign write_data     = wr_data_q;
    assign ld_err         = ld_err_q;

endmodule
